display_scan_scheduler: RTL and testbench

// Sequences the 4-digit multiplexed seven-segment display for the multi-cycle CPU board.

---
 rtl/display_scan_scheduler_pkg.sv | 34 +++
 rtl/display_scan_scheduler_prescaler.sv | 29 ++
 rtl/display_scan_scheduler.sv | 133 +++++++++++++
 tb/tb_display_scan_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/display_scan_scheduler_pkg.sv
// disp_pkg: shared constants for the seven-segment scan scheduler.
//   src_e             display owner encoding (NONE/DBG/RES/HALT)
//   AN_IDX0..AN_IDX3  active-low anode patterns for slot indices 0..3
//   HALT_CODE_DEFAULT word shown while the halt source owns the display
//   anode_for()       slot index -> anode pattern
package disp_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DBG  = 2'd1,
    SRC_RES  = 2'd2,
    SRC_HALT = 2'd3
  } src_e;

  localparam logic [3:0]  AN_IDX0 = 4'b0111;
  localparam logic [3:0]  AN_IDX1 = 4'b1011;
  localparam logic [3:0]  AN_IDX2 = 4'b1101;
  localparam logic [3:0]  AN_IDX3 = 4'b1110;
  localparam logic [3:0]  AN_OFF  = 4'b1111;

  localparam logic [15:0] HALT_CODE_DEFAULT = 16'hBBBB;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_IDX0;
      2'd1:    an = AN_IDX1;
      2'd2:    an = AN_IDX2;
      default: an = AN_IDX3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/display_scan_scheduler_prescaler.sv
// scan_prescaler: free-running divider producing the digit-slot tick.
//   clk    in  system clock
//   reset  in  synchronous active-high reset (counter back to 0)
//   tick   out high for the one cycle where the counter sits at SCAN_DIV-1
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: drives a 4-digit multiplexed seven-segment display
// and arbitrates three requesters (halt > result > debug) for its 16-bit word.
//   clk, reset        system clock, synchronous active-high reset
//   req_halt          halt/error request, shows HALT_CODE
//   req_result        result request, result_data sampled at commit
//   req_dbg           debug request, dbg_data sampled at commit
//   digit             registered nibble of the active digit
//   anode             registered active-low one-hot-zero anode enables
//   frame_done        one-cycle pulse at the end of the AN0 slot
//   src               current display owner (disp_pkg::src_e encoding)
module display_scan_scheduler
  import disp_pkg::*;
#(
  parameter int          SCAN_DIV   = 50000,
  parameter int          MIN_FRAMES = 2,
  parameter logic [15:0] HALT_CODE  = HALT_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_halt,
  input  logic        req_result,
  input  logic [15:0] result_data,
  input  logic        req_dbg,
  input  logic [15:0] dbg_data,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        frame_done,
  output logic [1:0]  src
);

  localparam int HW = $clog2(MIN_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_FRAMES);

  logic          w_tick;
  logic          w_fb;
  logic [1:0]    r_idx;
  logic [15:0]   r_word;
  src_e          r_src;
  logic [HW-1:0] r_hold;
  logic [3:0]    r_digit;
  logic [3:0]    r_anode;
  logic          r_frame_done;

  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_word_nxt;
  src_e          w_src_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [3:0]    w_digit_nxt;
  logic [3:0]    w_anode_nxt;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // The AN0 slot ends on the tick that moves idx from 3 back to 0.
  assign w_fb = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= 2'd3;
      r_word       <= '0;
      r_src        <= SRC_NONE;
      r_hold       <= '0;
      r_digit      <= '0;
      r_anode      <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_word       <= w_word_nxt;
      r_src        <= w_src_nxt;
      r_hold       <= w_hold_nxt;
      r_digit      <= w_digit_nxt;
      r_anode      <= w_anode_nxt;
      r_frame_done <= w_fb;
    end
  end

  // Ownership only changes at a frame boundary, so a word never changes mid-frame.
  always_comb begin
    w_src_nxt  = r_src;
    w_word_nxt = r_word;
    w_hold_nxt = r_hold;
    if (w_fb) begin
      if (req_halt) begin
        w_src_nxt  = SRC_HALT;
        w_word_nxt = HALT_CODE;
      end else if (r_src == SRC_RES && req_result) begin
        w_word_nxt = result_data;
      end else if (r_src == SRC_DBG && req_dbg) begin
        w_word_nxt = dbg_data;
      end else if (r_hold >= HOLD_MAX || r_src == SRC_NONE) begin
        if (req_result) begin
          w_src_nxt  = SRC_RES;
          w_word_nxt = result_data;
        end else if (req_dbg) begin
          w_src_nxt  = SRC_DBG;
          w_word_nxt = dbg_data;
        end
      end

      if (w_src_nxt != r_src)
        w_hold_nxt = '0;
      else if (r_hold < HOLD_MAX)
        w_hold_nxt = r_hold + 1'b1;
    end
  end

  // Digit load uses the post-commit word so the first digit of a new frame
  // already comes from the freshly committed value.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_digit_nxt = r_digit;
    w_anode_nxt = r_anode;
    if (w_tick) begin
      w_idx_nxt   = r_idx + 2'd1;
      w_anode_nxt = anode_for(w_idx_nxt);
      case (w_idx_nxt)
        2'd0:    w_digit_nxt = w_word_nxt[15:12];
        2'd1:    w_digit_nxt = w_word_nxt[11:8];
        2'd2:    w_digit_nxt = w_word_nxt[7:4];
        default: w_digit_nxt = w_word_nxt[3:0];
      endcase
    end
  end

  assign digit      = r_digit;
  assign anode      = r_anode;
  assign frame_done = r_frame_done;
  assign src        = r_src;

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  localparam int DIV = 4;
  localparam int MINF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_halt, req_result, req_dbg;
  logic [15:0] result_data, dbg_data;
  logic [3:0]  digit, anode;
  logic        frame_done;
  logic [1:0]  src;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state: counts of edges/ticks since reset, not register images
  int          m_edges, m_ticks, m_src, m_hold;
  logic [15:0] m_word;
  logic [3:0]  m_digit, m_anode;
  logic        m_fd;

  display_scan_scheduler #(.SCAN_DIV(DIV), .MIN_FRAMES(MINF), .HALT_CODE(16'hBBBB)) dut (
    .clk(clk), .reset(reset), .req_halt(req_halt), .req_result(req_result),
    .result_data(result_data), .req_dbg(req_dbg), .dbg_data(dbg_data),
    .digit(digit), .anode(anode), .frame_done(frame_done), .src(src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cur_slot();
    return (m_ticks + 3) % 4;
  endfunction

  function automatic bit next_is_fb();
    return ((m_edges % DIV) == DIV - 1) && (cur_slot() == 3);
  endfunction

  task automatic model_edge();
    bit tick, fb;
    int ns, nslot;
    logic [15:0] nw;
    if (reset) begin
      m_edges = 0; m_ticks = 0; m_src = 0; m_hold = 0;
      m_word = 16'h0; m_digit = 4'h0; m_anode = 4'hF; m_fd = 1'b0;
      return;
    end
    tick = ((m_edges % DIV) == DIV - 1);
    fb = tick && (cur_slot() == 3);
    if (fb) begin
      ns = m_src; nw = m_word;
      if (req_halt) begin ns = 3; nw = 16'hBBBB; end
      else if (m_src == 2 && req_result) nw = result_data;
      else if (m_src == 1 && req_dbg) nw = dbg_data;
      else if (m_hold >= MINF || m_src == 0) begin
        if (req_result) begin ns = 2; nw = result_data; end
        else if (req_dbg) begin ns = 1; nw = dbg_data; end
      end
      m_hold = (ns != m_src) ? 0 : ((m_hold + 1 > MINF) ? MINF : m_hold + 1);
      m_src = ns; m_word = nw;
    end
    if (tick) begin
      m_ticks++;
      nslot = cur_slot();
      m_digit = 4'((m_word >> (12 - 4 * nslot)) & 16'hF);
      m_anode = 4'(~(4'b1000 >> nslot));
    end
    m_fd = fb;
    m_edges++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("anode", {12'h0, anode}, {12'h0, m_anode});
    chk("digit", {12'h0, digit}, {12'h0, m_digit});
    chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    chk("src", {14'h0, src}, 16'(m_src));
  endtask

  initial begin
    int k, nfb;
    bit ok;
    reset = 1'b1; req_halt = 0; req_result = 0; req_dbg = 0;
    result_data = 16'h0; dbg_data = 16'h0;
    repeat (3) step();
    chk("rst_anode", {12'h0, anode}, 16'h000F);
    chk("rst_digit", {12'h0, digit}, 16'h0);
    chk("rst_src", {14'h0, src}, 16'h0);
    chk("rst_fd", {15'h0, frame_done}, 16'h0);

    // idle scan after release
    reset = 1'b0;
    repeat (3) begin step(); chk("idle_off", {12'h0, anode}, 16'h000F); end
    step(); chk("first_an3", {12'h0, anode}, 16'h0007);
    chk("first_fd", {15'h0, frame_done}, 16'h1);
    repeat (36) step();

    // result from NONE
    req_result = 1; result_data = 16'h12AB;
    ok = 0;
    for (k = 0; k < 40 && !ok; k++) begin step(); if (m_src == 2) ok = 1; end
    chk("res_commit_seen", 16'(ok), 16'h1);
    chk("res_src", {14'h0, src}, 16'h2);
    chk("res_d3", {12'h0, digit}, 16'h1);
    repeat (4) step(); chk("res_d2", {12'h0, digit}, 16'h2);
    repeat (4) step(); chk("res_d1", {12'h0, digit}, 16'hA);
    repeat (4) step(); chk("res_d0", {12'h0, digit}, 16'hB);

    // result drops, debug requested: held for MIN_FRAMES frames
    req_result = 0; req_dbg = 1; dbg_data = 16'h0F0F;
    ok = 0; nfb = 0;
    for (k = 0; k < 100 && !ok; k++) begin
      step();
      if (m_fd) nfb++;
      if (m_src == 1) ok = 1;
    end
    chk("dbg_switch_seen", 16'(ok), 16'h1);
    chk("dbg_hold_frames", 16'(nfb), 16'd3);
    chk("dbg_src", {14'h0, src}, 16'h1);
    chk("dbg_d3", {12'h0, digit}, 16'h0);

    // halt asserted the cycle before the next frame boundary
    ok = 0;
    for (k = 0; k < 40 && !ok; k++) begin if (next_is_fb()) ok = 1; else step(); end
    chk("halt_align", 16'(ok), 16'h1);
    req_halt = 1;
    step();
    chk("halt_src", {14'h0, src}, 16'h3);
    chk("halt_an", {12'h0, anode}, 16'h0007);
    chk("halt_digit", {12'h0, digit}, 16'hB);
    repeat (20) step();
    req_halt = 0; req_dbg = 0;
    repeat (40) step();

    // reset in slot 2
    ok = 0;
    for (k = 0; k < 40 && !ok; k++) begin step(); if (cur_slot() == 2) ok = 1; end
    chk("idx2_seen", 16'(ok), 16'h1);
    reset = 1; step();
    chk("mid_rst_anode", {12'h0, anode}, 16'h000F);
    chk("mid_rst_digit", {12'h0, digit}, 16'h0);
    chk("mid_rst_src", {14'h0, src}, 16'h0);
    reset = 0;
    repeat (3) begin step(); chk("rerun_off", {12'h0, anode}, 16'h000F); end

    // simultaneous result/debug from NONE, data changes mid-frame
    req_result = 1; result_data = 16'h12AB; req_dbg = 1; dbg_data = 16'h7777;
    step();
    chk("both_src", {14'h0, src}, 16'h2);
    chk("both_d3", {12'h0, digit}, 16'h1);
    repeat (6) step();
    result_data = 16'h3456;
    ok = 0;
    for (k = 0; k < 40 && !ok; k++) begin if (next_is_fb()) ok = 1; else step(); end
    chk("old_frame_d0", {12'h0, digit}, 16'hB);
    step();
    chk("new_frame_d3", {12'h0, digit}, 16'h3);
    req_result = 0; req_dbg = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req_result = ~req_result;
      if ($urandom_range(0, 7) == 0) req_dbg = ~req_dbg;
      if ($urandom_range(0, 31) == 0) req_halt = ~req_halt;
      if ($urandom_range(0, 3) == 0) result_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dbg_data = 16'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
